decode_execute_buffer: RTL and testbench

Elastic pipeline stage between instruction decode and execute. It captures the control bundle produced by the decoder's control unit, together with the decoded operands, and presents them to the execute stage under a valid/ready handshake. A two-entry skid buffer (main + skid) keeps the upstream ready signal registered. The block also supports flush and bubble insertion, and counts stall cycles for performance monitoring.

---
 rtl/pipeline_pkg.sv | 47 ++++
 rtl/pipe_entry.sv | 55 +++++
 rtl/decode_execute_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_decode_execute_buffer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Definitions shared by the decode/execute pipeline stages.
//   ctrl_t       : 13-bit control bundle from the decoder's control unit.
//                  The first field listed is the MSB.
//   CTRL_NOP     : all-zero control word. No write enable is set in it, so it
//                  is safe to present while no instruction is valid.
//   ALU_*        : aluControl operation codes.
//   buf_state_e  : occupancy of the decode/execute buffer, written as
//                  {mainValid, skidValid}.
// ---------------------------------------------------------------------------
package pipeline_pkg;

    typedef struct packed {
        logic       useScalarAlu;
        logic       isScalarOutput;
        logic       isScalarReg1;
        logic       isScalarReg2;
        logic       resultSelectorWB;
        logic       writeEnableScalarWB;
        logic       writeEnableVectorWB;
        logic       writeToMemoryEnableM;
        logic       useInmediate;
        logic [2:0] aluControl;
        logic       outFlagM;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SHL  = 3'b101;
    localparam logic [2:0] ALU_PASS = 3'b110;
    localparam logic [2:0] ALU_IMM  = 3'b111;

    // The encoding is the pair of entry valid bits. The pattern 2'b01
    // (skid entry valid while the main entry is empty) is illegal.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b10,
        BUF_FULL  = 2'b11
    } buf_state_e;

endpackage

// File: rtl/pipe_entry.sv
// ---------------------------------------------------------------------------
// pipe_entry
// One storage slot of the buffer: a payload register with a load enable,
// and a valid flag with separate set and clear controls.
// Ports:
//   clk      : clock, rising edge
//   nReset   : asynchronous active-low reset. Clears the payload and valid.
//   load_i   : capture data_i at the next edge
//   data_i   : payload to capture
//   set_i    : set the valid flag
//   clr_i    : clear the valid flag. Has priority over set_i.
//   data_o   : stored payload
//   valid_o  : valid flag
// ---------------------------------------------------------------------------
module pipe_entry #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             set_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    // The payload is written only on load. Outside of a load it holds its
    // value, so the data outputs keep their last value during bubbles.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end
    end

    // Clear has priority so that a flush always wins.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            valid_q <= 1'b0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (set_i) begin
            valid_q <= 1'b1;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/decode_execute_buffer.sv
// ---------------------------------------------------------------------------
// decode_execute_buffer
// Elastic stage between decode and execute. It holds two entries: the main
// entry drives the execute side, and the skid entry catches the one
// instruction that may arrive while execute stalls. Because of the skid
// entry, readyD can be a plain register.
// Ports:
//   clk, nReset                 : clock; asynchronous active-low reset
//   validD / readyD             : decode-side handshake (readyD is registered)
//   ctrlD, scalarAD, scalarBD,
//   vectorAD, vectorBD, immD,
//   destD                       : decode-side payload
//   flush                       : drop every buffered entry at the next edge
//   validE / readyE             : execute-side handshake
//   ctrlE ... destE             : execute-side payload. ctrlE is forced to
//                                 NOP while validE is low.
//   stallCount                  : saturating count of cycles with
//                                 validE && !readyE
// ---------------------------------------------------------------------------
module decode_execute_buffer
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int LANES          = 4,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int IMM_WIDTH      = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        nReset,
    input  logic                        validD,
    output logic                        readyD,
    input  ctrl_t                       ctrlD,
    input  logic [DATA_WIDTH-1:0]       scalarAD,
    input  logic [DATA_WIDTH-1:0]       scalarBD,
    input  logic [LANES*DATA_WIDTH-1:0] vectorAD,
    input  logic [LANES*DATA_WIDTH-1:0] vectorBD,
    input  logic [IMM_WIDTH-1:0]        immD,
    input  logic [REG_ADDR_WIDTH-1:0]   destD,
    input  logic                        flush,
    output logic                        validE,
    input  logic                        readyE,
    output ctrl_t                       ctrlE,
    output logic [DATA_WIDTH-1:0]       scalarAE,
    output logic [DATA_WIDTH-1:0]       scalarBE,
    output logic [LANES*DATA_WIDTH-1:0] vectorAE,
    output logic [LANES*DATA_WIDTH-1:0] vectorBE,
    output logic [IMM_WIDTH-1:0]        immE,
    output logic [REG_ADDR_WIDTH-1:0]   destE,
    output logic [CNT_WIDTH-1:0]        stallCount
);

    typedef struct packed {
        ctrl_t                       ctrl;
        logic [DATA_WIDTH-1:0]       scalarA;
        logic [DATA_WIDTH-1:0]       scalarB;
        logic [LANES*DATA_WIDTH-1:0] vectorA;
        logic [LANES*DATA_WIDTH-1:0] vectorB;
        logic [IMM_WIDTH-1:0]        imm;
        logic [REG_ADDR_WIDTH-1:0]   dest;
    } payload_t;

    localparam int PW = $bits(payload_t);

    payload_t   inPayload;
    payload_t   mainPayload;
    payload_t   skidPayload;
    payload_t   mainLoadData;
    logic       mainValid;
    logic       skidValid;
    logic       mainLoad;
    logic       mainFromSkid;
    logic       mainSet;
    logic       mainClr;
    logic       skidLoad;
    logic       skidSet;
    logic       skidClr;
    logic       inFire;
    logic       outFire;
    buf_state_e state;
    buf_state_e stateNext;
    logic       ready_q;
    logic       ready_d;
    logic [CNT_WIDTH-1:0] stall_q;
    logic [CNT_WIDTH-1:0] stall_d;

    assign inPayload = '{ctrl: ctrlD, scalarA: scalarAD, scalarB: scalarBD,
                         vectorA: vectorAD, vectorB: vectorBD, imm: immD,
                         dest: destD};

    assign mainLoadData = mainFromSkid ? skidPayload : inPayload;

    pipe_entry #(.WIDTH(PW)) u_main (
        .clk     (clk),
        .nReset  (nReset),
        .load_i  (mainLoad),
        .data_i  (mainLoadData),
        .set_i   (mainSet),
        .clr_i   (mainClr),
        .data_o  (mainPayload),
        .valid_o (mainValid)
    );

    pipe_entry #(.WIDTH(PW)) u_skid (
        .clk     (clk),
        .nReset  (nReset),
        .load_i  (skidLoad),
        .data_i  (inPayload),
        .set_i   (skidSet),
        .clr_i   (skidClr),
        .data_o  (skidPayload),
        .valid_o (skidValid)
    );

    // The entry valid flags are the state register, so the state is decoded
    // from them and is never stored twice.
    assign state   = buf_state_e'({mainValid, skidValid});
    assign inFire  = validD && ready_q;
    assign outFire = mainValid && readyE;

    // Next-state and entry controls. Flush overrides everything, and the
    // instruction offered in the same cycle is dropped.
    always_comb begin
        stateNext    = state;
        mainLoad     = 1'b0;
        mainFromSkid = 1'b0;
        mainSet      = 1'b0;
        mainClr      = 1'b0;
        skidLoad     = 1'b0;
        skidSet      = 1'b0;
        skidClr      = 1'b0;
        if (flush) begin
            mainClr   = 1'b1;
            skidClr   = 1'b1;
            stateNext = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (inFire) begin
                        mainLoad  = 1'b1;
                        mainSet   = 1'b1;
                        stateNext = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (inFire && outFire) begin
                        mainLoad = 1'b1;
                    end else if (inFire) begin
                        skidLoad  = 1'b1;
                        skidSet   = 1'b1;
                        stateNext = BUF_FULL;
                    end else if (outFire) begin
                        mainClr   = 1'b1;
                        stateNext = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (outFire) begin
                        mainLoad     = 1'b1;
                        mainFromSkid = 1'b1;
                        skidClr      = 1'b1;
                        stateNext    = BUF_ONE;
                    end
                end
                default: begin
                    mainClr   = 1'b1;
                    skidClr   = 1'b1;
                    stateNext = BUF_EMPTY;
                end
            endcase
        end
    end

    // readyD is registered. Its value is the inverse of the next skid
    // valid bit, so it drops in the cycle after the skid entry fills.
    assign ready_d = (stateNext != BUF_FULL);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= ready_d;
        end
    end

    // The stall counter saturates at all-ones. Only reset clears it.
    always_comb begin
        stall_d = stall_q;
        if (mainValid && !readyE && (stall_q != '1)) begin
            stall_d = stall_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign readyD     = ready_q;
    assign validE     = mainValid;
    assign ctrlE      = mainValid ? mainPayload.ctrl : CTRL_NOP;
    assign scalarAE   = mainPayload.scalarA;
    assign scalarBE   = mainPayload.scalarB;
    assign vectorAE   = mainPayload.vectorA;
    assign vectorBE   = mainPayload.vectorB;
    assign immE       = mainPayload.imm;
    assign destE      = mainPayload.dest;
    assign stallCount = stall_q;

endmodule

// File: tb/tb_decode_execute_buffer.sv
// ---------------------------------------------------------------------------
// tb_decode_execute_buffer
// Directed, table-driven bench for decode_execute_buffer, built with a 4-bit
// stall counter. Each table row gives the inputs applied before one rising
// edge and the outputs required just after that edge. The data payload of
// each instruction is derived from its destination register, so checking
// destE together with the derived data fields shows both ordering and
// payload integrity. Hand-written sequences cover counter saturation and
// asynchronous reset.
// ---------------------------------------------------------------------------
module tb_decode_execute_buffer;
    import pipeline_pkg::*;

    localparam int DW  = 16;
    localparam int LN  = 4;
    localparam int RW  = 4;
    localparam int IW  = 16;
    localparam int CW  = 4;
    localparam int NV  = 24;

    logic                clk;
    logic                nReset;
    logic                validD;
    logic                readyD;
    ctrl_t               ctrlD;
    logic [DW-1:0]       scalarAD;
    logic [DW-1:0]       scalarBD;
    logic [LN*DW-1:0]    vectorAD;
    logic [LN*DW-1:0]    vectorBD;
    logic [IW-1:0]       immD;
    logic [RW-1:0]       destD;
    logic                flush;
    logic                validE;
    logic                readyE;
    ctrl_t               ctrlE;
    logic [DW-1:0]       scalarAE;
    logic [DW-1:0]       scalarBE;
    logic [LN*DW-1:0]    vectorAE;
    logic [LN*DW-1:0]    vectorBE;
    logic [IW-1:0]       immE;
    logic [RW-1:0]       destE;
    logic [CW-1:0]       stallCount;

    int checks;
    int failures;

    typedef struct {
        logic        vD;
        logic [3:0]  dest;
        ctrl_t       ctrl;
        logic        rE;
        logic        fl;
        logic        eV;
        logic        eRdy;
        logic [3:0]  eDest;
        ctrl_t       eCtrl;
        logic [3:0]  eStall;
    } vec_t;

    vec_t vecs [NV];

    decode_execute_buffer #(
        .DATA_WIDTH     (DW),
        .LANES          (LN),
        .REG_ADDR_WIDTH (RW),
        .IMM_WIDTH      (IW),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk        (clk),
        .nReset     (nReset),
        .validD     (validD),
        .readyD     (readyD),
        .ctrlD      (ctrlD),
        .scalarAD   (scalarAD),
        .scalarBD   (scalarBD),
        .vectorAD   (vectorAD),
        .vectorBD   (vectorBD),
        .immD       (immD),
        .destD      (destD),
        .flush      (flush),
        .validE     (validE),
        .readyE     (readyE),
        .ctrlE      (ctrlE),
        .scalarAE   (scalarAE),
        .scalarBE   (scalarBE),
        .vectorAE   (vectorAE),
        .vectorBE   (vectorBE),
        .immE       (immE),
        .destE      (destE),
        .stallCount (stallCount)
    );

    // 10-time-unit clock with rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data patterns derived from the destination register. The immediate
    // has its MSB set, so any sign handling would corrupt it.
    function automatic logic [DW-1:0] patA(input logic [3:0] d);
        return 16'h1000 | {12'h000, d};
    endfunction

    function automatic logic [DW-1:0] patB(input logic [3:0] d);
        return 16'h2000 | {12'h000, d};
    endfunction

    function automatic logic [LN*DW-1:0] patVA(input logic [3:0] d);
        logic [DW-1:0] e;
        e = 16'h3000 | {12'h000, d};
        return {e, e ^ 16'h0100, e ^ 16'h0200, e ^ 16'h0300};
    endfunction

    function automatic logic [LN*DW-1:0] patVB(input logic [3:0] d);
        logic [DW-1:0] e;
        e = 16'h4000 | {12'h000, d};
        return {e, e, e, e};
    endfunction

    function automatic logic [IW-1:0] patImm(input logic [3:0] d);
        return 16'h8000 | {12'h000, d};
    endfunction

    function automatic vec_t mkVec(input logic vD, input logic [3:0] dest,
                                   input ctrl_t ctrl, input logic rE,
                                   input logic fl, input logic eV,
                                   input logic eRdy, input logic [3:0] eDest,
                                   input ctrl_t eCtrl, input logic [3:0] eStall);
        vec_t v;
        v.vD = vD; v.dest = dest; v.ctrl = ctrl; v.rE = rE; v.fl = fl;
        v.eV = eV; v.eRdy = eRdy; v.eDest = eDest; v.eCtrl = eCtrl;
        v.eStall = eStall;
        return v;
    endfunction

    // Drive all decode-side and execute-side inputs for the coming edge.
    task automatic applyStimulus(input vec_t v);
        validD   = v.vD;
        destD    = v.dest;
        ctrlD    = v.ctrl;
        readyE   = v.rE;
        flush    = v.fl;
        scalarAD = patA(v.dest);
        scalarBD = patB(v.dest);
        vectorAD = patVA(v.dest);
        vectorBD = patVB(v.dest);
        immD     = patImm(v.dest);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare every execute-side output against the row's expectation.
    task automatic checkRow(input string tag, input vec_t v);
        checkOutput({tag, " validE"}, 64'(validE), 64'(v.eV));
        checkOutput({tag, " readyD"}, 64'(readyD), 64'(v.eRdy));
        checkOutput({tag, " ctrlE"}, 64'(ctrlE), 64'(v.eCtrl));
        checkOutput({tag, " destE"}, 64'(destE), 64'(v.eDest));
        checkOutput({tag, " scalarAE"}, 64'(scalarAE), 64'(patA(v.eDest)));
        checkOutput({tag, " scalarBE"}, 64'(scalarBE), 64'(patB(v.eDest)));
        checkOutput({tag, " vectorAE"}, vectorAE, patVA(v.eDest));
        checkOutput({tag, " vectorBE"}, vectorBE, patVB(v.eDest));
        checkOutput({tag, " immE"}, 64'(immE), 64'(patImm(v.eDest)));
        checkOutput({tag, " stallCount"}, 64'(stallCount), 64'(v.eStall));
    endtask

    initial begin
        ctrl_t cS;
        ctrl_t cB;
        ctrl_t cW;
        vec_t  idle;

        checks   = 0;
        failures = 0;

        cS = CTRL_NOP;
        cS.aluControl = ALU_SUB;
        cB = CTRL_NOP;
        cB.useScalarAlu        = 1'b1;
        cB.writeEnableScalarWB = 1'b1;
        cB.aluControl          = ALU_ADD;
        cB.outFlagM            = 1'b1;
        cW = CTRL_NOP;
        cW.writeEnableVectorWB = 1'b1;
        cW.aluControl          = ALU_PASS;

        // Streaming at full rate with one cycle of latency.
        for (int i = 0; i < 8; i++) begin
            vecs[i] = mkVec(1, 4'(i), cS, 1, 0, 1, 1, 4'(i), cS, 0);
        end
        vecs[8]  = mkVec(0, 0, cS, 1, 0, 0, 1, 7, CTRL_NOP, 0);
        // Backpressure: dest 3 goes to main, dest 4 to skid, and dest 5 is refused.
        vecs[9]  = mkVec(1, 3, cB, 0, 0, 1, 1, 3, cB, 0);
        vecs[10] = mkVec(1, 4, cB, 0, 0, 1, 0, 3, cB, 1);
        vecs[11] = mkVec(1, 5, cB, 0, 0, 1, 0, 3, cB, 2);
        vecs[12] = mkVec(0, 5, cB, 1, 0, 1, 1, 4, cB, 2);
        vecs[13] = mkVec(0, 5, cB, 1, 0, 0, 1, 4, CTRL_NOP, 2);
        // Flush while FULL, with dest 9 offered at the same time.
        vecs[14] = mkVec(1, 10, cB, 0, 0, 1, 1, 10, cB, 2);
        vecs[15] = mkVec(1, 11, cB, 0, 0, 1, 0, 10, cB, 3);
        vecs[16] = mkVec(1, 9, cB, 0, 1, 0, 1, 10, CTRL_NOP, 4);
        vecs[17] = mkVec(0, 9, cB, 1, 0, 0, 1, 10, CTRL_NOP, 4);
        // Flush in ONE with readyE=1 and a new instruction offered: main is consumed, dest 9 is dropped.
        vecs[18] = mkVec(1, 12, cS, 1, 0, 1, 1, 12, cS, 4);
        vecs[19] = mkVec(1, 9, cS, 1, 1, 0, 1, 12, CTRL_NOP, 4);
        // Bubbles after a vector write. ctrlD keeps the write bit throughout.
        vecs[20] = mkVec(1, 5, cW, 1, 0, 1, 1, 5, cW, 4);
        for (int i = 21; i < 24; i++) begin
            vecs[i] = mkVec(0, 5, cW, 1, 0, 0, 1, 5, CTRL_NOP, 4);
        end

        // Hold reset across two edges. Outputs must be at reset values.
        idle = mkVec(0, 0, CTRL_NOP, 0, 0, 0, 1, 0, CTRL_NOP, 0);
        nReset = 1'b0;
        applyStimulus(idle);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset validE", 64'(validE), 64'(0));
        checkOutput("reset readyD", 64'(readyD), 64'(1));
        checkOutput("reset ctrlE", 64'(ctrlE), 64'(0));
        checkOutput("reset stallCount", 64'(stallCount), 64'(0));
        checkOutput("reset destE", 64'(destE), 64'(0));
        checkOutput("reset vectorAE", vectorAE, 64'(0));
        nReset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkRow($sformatf("row%0d", i), vecs[i]);
        end

        // Saturation: hold one entry with readyE low until the 4-bit counter
        // reaches 15, then confirm it stays there.
        applyStimulus(mkVec(1, 6, cB, 0, 0, 0, 0, 0, CTRL_NOP, 0));
        @(posedge clk);
        #1;
        checkOutput("sat load validE", 64'(validE), 64'(1));
        checkOutput("sat load destE", 64'(destE), 64'(6));
        checkOutput("sat load stallCount", 64'(stallCount), 64'(4));
        validD = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("sat stallCount", 64'(stallCount), 64'(15));
        checkOutput("sat validE", 64'(validE), 64'(1));
        @(posedge clk);
        #1;
        checkOutput("sat hold stallCount", 64'(stallCount), 64'(15));

        // Asynchronous reset applied between edges. Its effect must be visible
        // before the next rising edge.
        #2;
        nReset = 1'b0;
        #1;
        checkOutput("async validE", 64'(validE), 64'(0));
        checkOutput("async readyD", 64'(readyD), 64'(1));
        checkOutput("async ctrlE", 64'(ctrlE), 64'(0));
        checkOutput("async destE", 64'(destE), 64'(0));
        checkOutput("async scalarAE", 64'(scalarAE), 64'(0));
        checkOutput("async immE", 64'(immE), 64'(0));
        checkOutput("async stallCount", 64'(stallCount), 64'(0));
        #3;
        nReset = 1'b1;

        // The buffer accepts new work again after reset is released.
        applyStimulus(mkVec(1, 13, cS, 1, 0, 0, 0, 0, CTRL_NOP, 0));
        @(posedge clk);
        #1;
        checkRow("post-reset", mkVec(1, 13, cS, 1, 0, 1, 1, 13, cS, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
